// File: rtl/xor_pkg.sv
// Shared definitions for the xor_block datapath and its chunk assembler.
// Holds the byte width, the assembler FSM states and the byte-lane position helper.
package xor_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Bit position of the LSB of byte k in an nb-byte chunk; byte 0 sits in the top lane.
    function automatic int lane_lsb(input int nb, input int k);
        return BYTE_W * (nb - 1 - k);
    endfunction

endpackage

// File: rtl/xor_chunk_assembler.sv
// Collects a serial byte stream into n-byte chunks, pads a short final chunk and
// presents it with a key snapshot on a valid/ready interface feeding xor_block.
module xor_chunk_assembler
    import xor_pkg::*;
#(
    parameter int         n   = 2,
    parameter logic [7:0] PAD = 8'h00
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_load,
    input  logic [8*n-1:0]           key_in,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8*n-1:0]           chunk,
    output logic [8*n-1:0]           key,
    output logic [$clog2(n+1)-1:0]   out_bytes,
    output logic                     out_last
);

    localparam int CNT_W = $clog2(n + 1);
    localparam int CW    = BYTE_W * n;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [CW-1:0]    buf_reg;
    logic [CW-1:0]    buf_next;
    logic [CW-1:0]    key_reg;
    logic [CW-1:0]    snap_reg;
    logic [CNT_W-1:0] bytes_reg;
    logic             last_reg;

    logic accept;
    logic last_slot;
    logic finish;

    // Acceptance is decoded from the state directly so it does not loop through in_ready.
    assign accept    = in_valid && (state_reg == FILL);
    assign last_slot = (count_reg == CNT_W'(n - 1));
    assign finish    = accept && (last_slot || in_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= FILL;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            FILL: begin
                in_ready = 1'b1;
                if (finish) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = FILL;
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    always_comb begin
        count_next = count_reg;
        if (finish) begin
            count_next = '0;
        end else if (accept) begin
            count_next = count_reg + CNT_W'(1);
        end else if (state_reg == HOLD && out_ready) begin
            count_next = '0;
        end
    end

    // Each lane either takes the incoming byte, becomes padding on a short final
    // chunk, or keeps its value.
    for (genvar gi = 0; gi < n; gi++) begin : g_lane
        localparam int LSB = lane_lsb(n, gi);
        logic [BYTE_W-1:0] lane_next;

        always_comb begin
            lane_next = buf_reg[LSB +: BYTE_W];
            if (accept && count_reg == CNT_W'(gi)) begin
                lane_next = in_data;
            end else if (finish && count_reg < CNT_W'(gi)) begin
                lane_next = PAD;
            end
        end

        assign buf_next[LSB +: BYTE_W] = lane_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
            buf_reg   <= '0;
            key_reg   <= '0;
            snap_reg  <= '0;
            bytes_reg <= '0;
            last_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            buf_reg   <= buf_next;
            if (key_load) begin
                key_reg <= key_in;
            end
            // Snapshot takes the pre-load register value when a load coincides.
            if (finish) begin
                snap_reg  <= key_reg;
                bytes_reg <= count_reg + CNT_W'(1);
                last_reg  <= in_last;
            end
        end
    end

    assign chunk     = buf_reg;
    assign key       = snap_reg;
    assign out_bytes = bytes_reg;
    assign out_last  = last_reg;

endmodule

// File: tb/tb_xor_chunk_assembler.sv
// Self-checking bench for xor_chunk_assembler: directed scenarios plus random
// traffic compared against a queue-based message/chunk model.
module tb_xor_chunk_assembler;

    localparam int         N   = 2;
    localparam logic [7:0] PAD = 8'h00;
    localparam int         BW  = $clog2(N + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           key_load = 1'b0;
    logic [8*N-1:0] key_in = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [7:0]     in_data = '0;
    logic           in_last = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [8*N-1:0] chunk;
    logic [8*N-1:0] key;
    logic [BW-1:0]  out_bytes;
    logic           out_last;

    xor_chunk_assembler #(.n(N), .PAD(PAD)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_load  (key_load),
        .key_in    (key_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .chunk     (chunk),
        .key       (key),
        .out_bytes (out_bytes),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: bytes of the chunk being gathered, the key register, and the
    // chunk awaiting handshake.
    logic [7:0]     m_bytes[$];
    logic [8*N-1:0] m_key = '0;
    bit             m_hold = 1'b0;
    logic [8*N-1:0] m_exp_chunk = '0;
    logic [8*N-1:0] m_exp_key = '0;
    int             m_exp_bytes = 0;
    bit             m_exp_last = 1'b0;

    logic [8*N-1:0] hs_chunk[$];
    bit             hs_last[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8*N-1:0] build_chunk();
        logic [8*N-1:0] v = '0;
        for (int i = 0; i < N; i++) begin
            v = v << 8;
            v[7:0] = (i < m_bytes.size()) ? m_bytes[i] : PAD;
        end
        return v;
    endfunction

    // Compare outputs against the model, advance the model with the current inputs, clock.
    task automatic cycle();
        logic [8*N-1:0] next_key;
        check("in_ready", in_ready, !m_hold);
        check("out_valid", out_valid, m_hold);
        if (m_hold) begin
            check("chunk", chunk, m_exp_chunk);
            check("key", key, m_exp_key);
            check("out_bytes", out_bytes, m_exp_bytes);
            check("out_last", out_last, m_exp_last);
        end
        next_key = key_load ? key_in : m_key;
        if (!m_hold && in_valid) begin
            m_bytes.push_back(in_data);
            if (m_bytes.size() == N || in_last) begin
                m_exp_chunk = build_chunk();
                m_exp_key   = m_key;
                m_exp_bytes = m_bytes.size();
                m_exp_last  = in_last;
                m_hold      = 1'b1;
                m_bytes.delete();
            end
        end else if (m_hold && out_ready) begin
            $display("chunk %h key %h bytes %0d last %0d", chunk, key, out_bytes, out_last);
            hs_chunk.push_back(chunk);
            hs_last.push_back(out_last);
            m_hold = 1'b0;
        end
        m_key = next_key;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        key_load = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_bytes.delete();
        m_key  = '0;
        m_hold = 1'b0;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_chunk", chunk, '0);
        check("rst_key", key, '0);
        check("rst_out_bytes", out_bytes, '0);
        check("rst_out_last", out_last, 1'b0);
    endtask

    // Present a byte until the model says it has been accepted.
    task automatic send(input logic [7:0] b, input bit last);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        for (int t = 0; t < 20 && !acc; t++) begin
            acc = !m_hold;
            cycle();
        end
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic load_key(input logic [8*N-1:0] k);
        key_load = 1'b1;
        key_in   = k;
        cycle();
        key_load = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int t = 0; t < 20 && m_hold; t++) cycle();
        if (m_hold) check("drain_timeout", 0, 1);
        out_ready = 1'b0;
    endtask

    initial begin
        do_reset();
        cycle();

        // Full two-byte message "fe"
        load_key(16'h4868);
        send("f", 1'b0);
        send("e", 1'b1);
        check("t1_valid", out_valid, 1'b1);
        check("t1_chunk", chunk, 16'h6665);
        check("t1_key", key, 16'h4868);
        check("t1_bytes", out_bytes, 2);
        check("t1_last", out_last, 1'b1);
        drain();

        // Short message "a" gets padded
        send("a", 1'b1);
        check("t2_chunk", chunk, 16'h6100);
        check("t2_bytes", out_bytes, 1);
        check("t2_last", out_last, 1'b1);
        drain();

        // Backpressure with unconsumed input and a key load during HOLD
        load_key(16'h6162);
        send("a", 1'b0);
        send("b", 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hee;
        for (int i = 0; i < 3; i++) begin
            key_load = (i == 1);
            key_in   = 16'h0000;
            cycle();
        end
        key_load = 1'b0;
        in_valid = 1'b0;
        check("t3_chunk", chunk, 16'h6162);
        check("t3_last", out_last, 1'b0);
        check("t4_key_held", key, 16'h6162);
        check("t3_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        check("t3_refill", in_ready, 1'b1);
        send("c", 1'b0);
        send("d", 1'b1);
        check("t4_chunk", chunk, 16'h6364);
        check("t4_key_new", key, 16'h0000);
        drain();

        // Reset in the middle of a chunk discards it and clears the key
        load_key(16'hbeef);
        send("x", 1'b0);
        do_reset();
        send("y", 1'b0);
        send("z", 1'b1);
        check("t5_chunk", chunk, 16'h797a);
        check("t5_key", key, 16'h0000);
        drain();

        // Four-byte message at full rate
        hs_chunk.delete();
        hs_last.delete();
        out_ready = 1'b1;
        send("w", 1'b0);
        send("x", 1'b0);
        send("y", 1'b0);
        send("z", 1'b1);
        drain();
        check("t6_count", hs_chunk.size(), 2);
        if (hs_chunk.size() >= 2) begin
            check("t6_chunk0", hs_chunk[0], 16'h7778);
            check("t6_last0", hs_last[0], 1'b0);
            check("t6_chunk1", hs_chunk[1], 16'h797a);
            check("t6_last1", hs_last[1], 1'b1);
        end

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            key_load  = ($urandom_range(0, 7) == 0);
            key_in    = (8*N)'($urandom);
            if ($urandom_range(0, 99) == 0) do_reset();
            else cycle();
        end
        in_valid = 1'b0;
        key_load = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/xor_chunk_assembler.md
Name: xor_chunk_assembler

Overview:
Upstream feeder for xor_block. It collects a serial byte stream into n-byte chunks and pads a short final chunk. It presents each chunk together with a stable snapshot of the key on a valid/ready output. The chunk and key outputs connect directly to xor_block's chunk and key inputs.

Parameters:
n, 2, bytes per chunk; chunk and key width is 8*n; n >= 1
PAD, 8'h00, byte value used to fill the unused low positions of a short final chunk

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
key_load  input  1  load key_in into the internal key register this cycle
key_in  input  8*n  new key value
in_valid  input  1  in_data/in_last are valid
in_ready  output  1  block accepts a byte this cycle
in_data  input  8  byte from the stream
in_last  input  1  marks the final byte of a message
out_valid  output  1  chunk/key/out_bytes/out_last are valid
out_ready  input  1  downstream consumes the chunk this cycle
chunk  output  8*n  assembled chunk, first-received byte in bits [8n-1:8n-8]
key  output  8*n  key snapshot belonging to this chunk
out_bytes  output  $clog2(n+1)  number of real (non-pad) bytes in chunk, 1..n
out_last  output  1  chunk contains the message's last byte

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=FILL, byte count=0, chunk buffer=0, key register=0, key snapshot=0.
  - out_valid=0, out_bytes=0, out_last=0.
  - in_ready is 1 from the first cycle after reset.
- FSM has two states, FILL and HOLD.
- FILL:
  - in_ready=1 and out_valid=0.
  - A byte is accepted when in_valid and in_ready are both 1.
  - Byte k (k=0..n-1) of the chunk is written to bits [8(n-k)-1 : 8(n-k-1)]; the count then increments.
- FILL -> HOLD transition happens on the accepting edge when the count reaches n, or when in_last=1.
  - On that edge, positions k+1..n-1 are filled with PAD.
  - out_bytes = k+1; out_last = in_last.
  - The key register is copied into the key snapshot.
- HOLD:
  - in_ready=0 and out_valid=1.
  - chunk, key, out_bytes and out_last are held stable until the handshake.
  - When out_ready=1 at an edge: transition to FILL, count cleared, out_valid drops the next cycle.
- Latency: out_valid rises the cycle after the final byte of a chunk is accepted.
- Throughput: n+1 cycles per chunk at full rate (one bubble for the HOLD handshake). This is accepted by design.
- Key register:
  - key_load loads key_in on any edge, in either state.
  - The key output always shows the snapshot, so a load during HOLD does not change the current output.
  - The new key takes effect from the next chunk onward.
- Simultaneous key_load and the final-byte accept on the same edge: the snapshot takes the old register value. The new key applies to the following chunk.
- in_last with count already at n-1: this is a full chunk with out_bytes=n and no padding.
- in_valid while in_ready=0: ignored; the data is not consumed.
- Reset mid-FILL or mid-HOLD: the partial or unconsumed chunk is discarded with no output, and the key is cleared.
- Out-of-range count is unreachable; the count wraps only via the explicit clear.

Decomposition:
- Shared package xor_pkg contains:
  - BYTE_W=8 constant.
  - state_t enum {FILL, HOLD}.
  - A helper function for the byte lane index.
- xor_block is also parameterised through n, so both blocks share the same n.
- No sub-module is needed. The assembler is one module with the FSM, the count, the buffer and the key registers.

Test Plan:
1. n=2, key_load with key_in=16'h4868 ("Hh"); bytes "f","e" (in_last on "e") -> chunk=16'h6665, key=16'h4868, out_bytes=2, out_last=1, out_valid the cycle after "e".
2. Single byte "a" with in_last -> chunk=16'h6100 (PAD=00), out_bytes=1, out_last=1.
3. Backpressure: out_ready held 0 for 3 cycles after chunk "ab" (16'h6162) -> outputs stable, in_ready=0, in_valid bytes not consumed; out_ready=1 -> FILL the next cycle.
4. key_load with key_in=16'h0000 during HOLD of chunk "ab" with key 16'h6162 -> key output stays 16'h6162; the next chunk "cd" shows key 16'h0000.
5. rst=1 after one byte "x" is accepted -> no out_valid; the next bytes "y","z" yield chunk=16'h797A and key=16'h0000.
6. Stream of 4 bytes "w","x","y","z" (in_last on "z") -> two chunks, 16'h7778 with out_last=0, then 16'h797A with out_last=1; out_bytes=2 for both.
